// File: rtl/pipe_stage_skid.sv
// rtl/pipe_stage_skid.sv - pipeline stage: single register (SKID=0) or two-entry skid buffer (SKID=1)
// Control field is cleared on flush and gated to zero whenever the head is not valid.
module pipe_stage_skid #(
  parameter int DATA_W = 108,
  parameter int CTRL_W = 7,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t              state, state_nxt;
  logic                accept, pop;
  logic                load_head_in, load_head_skid, load_skid;
  logic [DATA_W-1:0]   head_data, skid_data;
  logic [CTRL_W-1:0]   head_ctrl, skid_ctrl;

  assign out_valid = (state != EMPTY);

  // SKID=1 keeps out_ready off the in_ready path: in_ready decodes registered state only.
  if (SKID == 0) begin : g_reg
    assign in_ready = !out_valid || out_ready;
  end else begin : g_skid
    assign in_ready = (state != FULL);
  end

  assign accept = in_valid && in_ready && !flush;
  assign pop    = out_valid && out_ready && !flush;

  always_comb begin
    state_nxt      = state;
    load_head_in   = 1'b0;
    load_head_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            state_nxt    = ONE;
            load_head_in = 1'b1;
          end
        end
        ONE: begin
          if (accept && !pop) begin
            state_nxt = FULL;
            load_skid = 1'b1;
          end else if (accept && pop) begin
            state_nxt    = ONE;
            load_head_in = 1'b1;
          end else if (pop) begin
            state_nxt = EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            state_nxt      = ONE;
            load_head_skid = 1'b1;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= EMPTY;
      head_data <= '0;
      head_ctrl <= '0;
      skid_data <= '0;
      skid_ctrl <= '0;
    end else begin
      state <= state_nxt;
      if (flush) begin
        head_ctrl <= '0;
        skid_ctrl <= '0;
      end else begin
        if (load_head_in) begin
          head_data <= in_data;
          head_ctrl <= in_ctrl;
        end else if (load_head_skid) begin
          head_data <= skid_data;
          head_ctrl <= skid_ctrl;
        end
        if (load_skid) begin
          skid_data <= in_data;
          skid_ctrl <= in_ctrl;
        end
      end
    end
  end

  assign out_data  = head_data;
  assign out_ctrl  = out_valid ? head_ctrl : '0;
  assign occupancy = (state == FULL) ? 2'd2 : ((state == ONE) ? 2'd1 : 2'd0);

endmodule
